// File: rtl/motion_system_core_pkg.sv
// -----------------------------------------------------------------------------
// motion_system_core_pkg
// Shared types and constants for the motion-control core: channel count, byte
// type, packet command/status codes, register map offsets, the ID word, the
// FSM state type and the request status decoder.
// -----------------------------------------------------------------------------
package motion_system_core_pkg;

    localparam int NOS_PWM_CHANNELS = 4;

    typedef logic [7:0] byte_t;

    // Packet command codes
    localparam byte_t CMD_WRITE = 8'h00;
    localparam byte_t CMD_READ  = 8'h01;

    // Reply status codes
    localparam byte_t STATUS_OK      = 8'h00;
    localparam byte_t STATUS_BAD_REG = 8'h01;
    localparam byte_t STATUS_BAD_CMD = 8'h02;

    // Global register numbers
    localparam byte_t REG_ID         = 8'd0;
    localparam byte_t REG_STATUS     = 8'd1;
    localparam byte_t REG_GLOBAL_CFG = 8'd2;
    localparam byte_t REG_CH_BASE    = 8'd3;
    localparam byte_t REG_LIMIT      = 8'(3 + 4 * NOS_PWM_CHANNELS);

    // Offsets inside one channel's 4-register block
    localparam logic [1:0] CH_PERIOD  = 2'd0;
    localparam logic [1:0] CH_ON_TIME = 2'd1;
    localparam logic [1:0] CH_CONFIG  = 2'd2;
    localparam logic [1:0] CH_COUNT   = 2'd3;

    localparam logic [31:0] ID_VALUE = 32'h4D4F5431;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_RX_WAIT_H1_HI = 3'd1,
        ST_RX_WAIT_H1_LO = 3'd2,
        ST_EXECUTE       = 3'd3,
        ST_TX_WAIT_H1_HI = 3'd4,
        ST_TX_WAIT_H1_LO = 3'd5,
        ST_DONE          = 3'd6
    } state_t;

    // True for registers that reject writes (ID, status, encoder counts).
    function automatic logic is_read_only(input byte_t regno);
        byte_t rel;
        logic  ro;
        rel = regno - REG_CH_BASE;
        if (regno < REG_CH_BASE) begin
            ro = (regno != REG_GLOBAL_CFG);
        end else begin
            ro = (rel[1:0] == CH_COUNT);
        end
        return ro;
    endfunction

    // Status of a request; a bad command takes precedence over a bad register.
    function automatic byte_t decode_status(input byte_t cmd, input byte_t regno);
        byte_t status;
        if ((cmd != CMD_WRITE) && (cmd != CMD_READ)) begin
            status = STATUS_BAD_CMD;
        end else if (regno >= REG_LIMIT) begin
            status = STATUS_BAD_REG;
        end else if ((cmd == CMD_WRITE) && is_read_only(regno)) begin
            status = STATUS_BAD_REG;
        end else begin
            status = STATUS_OK;
        end
        return status;
    endfunction

endpackage

// File: rtl/motion_system_core_if.sv
// -----------------------------------------------------------------------------
// motion_system_core_if
// Byte-wide 4-phase handshake bus between the host uP (master) and the FPGA
// core (slave).
//   uP_start       : uP -> FPGA, high for the whole transaction
//   uP_handshake_1 : uP -> FPGA strobe
//   uP_data_out    : uP -> FPGA byte
//   uP_handshake_2 : FPGA -> uP strobe
//   uP_data_in     : FPGA -> uP byte
//   uP_ack         : FPGA -> uP transaction complete
// -----------------------------------------------------------------------------
interface motion_system_core_if;
    import motion_system_core_pkg::*;

    logic  uP_start;
    logic  uP_handshake_1;
    byte_t uP_data_out;
    logic  uP_handshake_2;
    byte_t uP_data_in;
    logic  uP_ack;

    modport master (
        output uP_start, uP_handshake_1, uP_data_out,
        input  uP_handshake_2, uP_data_in, uP_ack
    );

    modport slave (
        input  uP_start, uP_handshake_1, uP_data_out,
        output uP_handshake_2, uP_data_in, uP_ack
    );

endinterface

// File: rtl/motion_system_core_channel.sv
// -----------------------------------------------------------------------------
// motion_system_core_channel
// One motor channel: period / on-time / config registers, PWM generator and
// x4 quadrature encoder counter with optional index clear.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_wr_en, i_sel    : register write strobe and register select (0..3)
//   i_wr_data         : write data
//   i_quad_a/b/i      : raw (asynchronous) encoder phases and index
//   o_rd_data         : contents of the register selected by i_sel
//   o_pwm             : registered PWM output
// -----------------------------------------------------------------------------
module motion_system_core_channel
    import motion_system_core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_wr_data,
    input  logic        i_quad_a,
    input  logic        i_quad_b,
    input  logic        i_quad_i,
    output logic [31:0] o_rd_data,
    output logic        o_pwm
);

    logic [31:0] r_period;      // programmed period (what the host reads back)
    logic [31:0] r_period_act;  // period in use; reloaded only at a wrap
    logic [31:0] r_on_time;
    logic [1:0]  r_cfg;         // bit0 PWM enable, bit1 index-clear enable
    logic [31:0] r_pwm_cnt;
    logic        r_pwm;
    logic [31:0] r_count;
    logic [2:0]  r_q_meta;      // {I, B, A}
    logic [2:0]  r_q_sync;
    logic [2:0]  r_q_prev;

    logic w_run;
    logic w_step_up;
    logic w_step_dn;
    logic w_index_clr;

    assign w_run       = r_cfg[0] && (r_period_act != 32'd0);
    assign w_index_clr = r_cfg[1] && r_q_sync[2] && !r_q_prev[2];
    assign o_pwm       = r_pwm;

    // Host register writes; the encoder count is read-only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_period  <= 32'd0;
            r_on_time <= 32'd0;
            r_cfg     <= 2'b00;
        end else if (i_wr_en) begin
            case (i_sel)
                CH_PERIOD:  r_period  <= i_wr_data;
                CH_ON_TIME: r_on_time <= i_wr_data;
                CH_CONFIG:  r_cfg     <= i_wr_data[1:0];
                default:    r_cfg     <= r_cfg;
            endcase
        end
    end

    // Register read-back mux.
    always_comb begin
        o_rd_data = 32'd0;
        case (i_sel)
            CH_PERIOD:  o_rd_data = r_period;
            CH_ON_TIME: o_rd_data = r_on_time;
            CH_CONFIG:  o_rd_data = {30'd0, r_cfg};
            CH_COUNT:   o_rd_data = r_count;
            default:    o_rd_data = 32'd0;
        endcase
    end

    // PWM counter; a new period is picked up only at a wrap or while idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_cnt    <= 32'd0;
            r_period_act <= 32'd0;
            r_pwm        <= 1'b0;
        end else begin
            if (!w_run) begin
                r_pwm_cnt    <= 32'd0;
                r_period_act <= r_period;
            end else if (r_pwm_cnt >= (r_period_act - 32'd1)) begin
                r_pwm_cnt    <= 32'd0;
                r_period_act <= r_period;
            end else begin
                r_pwm_cnt    <= r_pwm_cnt + 32'd1;
            end
            r_pwm <= w_run && (r_pwm_cnt < r_on_time);
        end
    end

    // Two-flop synchronisers for A, B, I plus one history stage for edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q_meta <= 3'b000;
            r_q_sync <= 3'b000;
            r_q_prev <= 3'b000;
        end else begin
            r_q_meta <= {i_quad_i, i_quad_b, i_quad_a};
            r_q_sync <= r_q_meta;
            r_q_prev <= r_q_sync;
        end
    end

    // x4 decode on {A_prev, B_prev, A, B}; double-phase changes fall to default.
    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        case ({r_q_prev[0], r_q_prev[1], r_q_sync[0], r_q_sync[1]})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step_up = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step_dn = 1'b1;
            default: begin
                w_step_up = 1'b0;
                w_step_dn = 1'b0;
            end
        endcase
    end

    // Encoder position counter; index clear overrides a coincident step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 32'd0;
        end else if (w_index_clr) begin
            r_count <= 32'd0;
        end else if (w_step_up) begin
            r_count <= r_count + 32'd1;
        end else if (w_step_dn) begin
            r_count <= r_count - 32'd1;
        end
    end

endmodule

// File: rtl/motion_system_core.sv
// -----------------------------------------------------------------------------
// motion_system_core
// Top level: packet FSM on the uP handshake bus, register decode and the
// generated motor channels.
//   CLOCK_50                : 50 MHz system clock
//   reset                   : asynchronous active-high reset
//   quadrature_A/B/I        : per-channel encoder inputs (asynchronous)
//   up_bus                  : uP handshake bus (slave side)
//   pwm_out                 : per-channel PWM outputs
// -----------------------------------------------------------------------------
module motion_system_core
    import motion_system_core_pkg::*;
(
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_A,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_B,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_I,
    motion_system_core_if.slave         up_bus,
    output logic [NOS_PWM_CHANNELS-1:0] pwm_out
);

    state_t      r_state;
    logic        r_start_meta, r_start_sync;
    logic        r_h1_meta, r_h1_sync;
    logic [2:0]  r_byte_idx;
    byte_t       r_pkt [6];
    byte_t       r_tx  [5];
    logic [2:0]  r_tx_len;
    logic [2:0]  r_tx_idx;
    logic        r_h2;
    byte_t       r_data_in;
    logic        r_ack;
    logic [31:0] r_gcfg;

    byte_t       w_cmd, w_reg, w_status, w_ch_rel;
    logic [31:0] w_wdata, w_rd_data, w_ch_rd_any;
    logic        w_wr_en, w_in_ch_range, w_busy;
    logic [5:0]  w_ch_num;
    logic [1:0]  w_ch_sel;
    logic [NOS_PWM_CHANNELS-1:0] w_ch_hit;
    logic [31:0] w_ch_rd [NOS_PWM_CHANNELS];

    assign w_cmd         = r_pkt[0];
    assign w_reg         = r_pkt[1];
    assign w_wdata       = {r_pkt[5], r_pkt[4], r_pkt[3], r_pkt[2]};
    assign w_status      = decode_status(w_cmd, w_reg);
    assign w_wr_en       = (r_state == ST_EXECUTE) && (w_cmd == CMD_WRITE) && (w_status == STATUS_OK);
    assign w_in_ch_range = (w_reg >= REG_CH_BASE) && (w_reg < REG_LIMIT);
    assign w_ch_rel      = w_reg - REG_CH_BASE;
    assign w_ch_num      = w_ch_rel[7:2];
    assign w_ch_sel      = w_ch_rel[1:0];
    assign w_busy        = (r_state != ST_IDLE);

    assign up_bus.uP_handshake_2 = r_h2;
    assign up_bus.uP_data_in     = r_data_in;
    assign up_bus.uP_ack         = r_ack;

    for (genvar gi = 0; gi < NOS_PWM_CHANNELS; gi++) begin : g_ch
        assign w_ch_hit[gi] = w_in_ch_range && (w_ch_num == 6'(gi));
        motion_system_core_channel u_channel (
            .i_clk     (CLOCK_50),
            .i_rst     (reset),
            .i_wr_en   (w_wr_en && w_ch_hit[gi]),
            .i_sel     (w_ch_sel),
            .i_wr_data (w_wdata),
            .i_quad_a  (quadrature_A[gi]),
            .i_quad_b  (quadrature_B[gi]),
            .i_quad_i  (quadrature_I[gi]),
            .o_rd_data (w_ch_rd[gi]),
            .o_pwm     (pwm_out[gi])
        );
    end

    // Read mux: global registers, else the addressed channel (zero if none).
    always_comb begin
        w_ch_rd_any = 32'd0;
        for (int n = 0; n < NOS_PWM_CHANNELS; n++) begin
            w_ch_rd_any = w_ch_rd_any | (w_ch_hit[n] ? w_ch_rd[n] : 32'd0);
        end
        w_rd_data = 32'd0;
        case (w_reg)
            REG_ID:         w_rd_data = ID_VALUE;
            REG_STATUS:     w_rd_data = {31'd0, w_busy};
            REG_GLOBAL_CFG: w_rd_data = r_gcfg;
            default:        w_rd_data = w_ch_rd_any;
        endcase
    end

    // Spare global configuration register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_gcfg <= 32'd0;
        end else if (w_wr_en && (w_reg == REG_GLOBAL_CFG)) begin
            r_gcfg <= w_wdata;
        end
    end

    // Two-flop synchronisers for the uP start and strobe lines.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_h1_meta    <= 1'b0;
            r_h1_sync    <= 1'b0;
        end else begin
            r_start_meta <= up_bus.uP_start;
            r_start_sync <= r_start_meta;
            r_h1_meta    <= up_bus.uP_handshake_1;
            r_h1_sync    <= r_h1_meta;
        end
    end

    // Packet FSM: receive 6 bytes, execute, send reply, then ack.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= 3'd0;
            r_tx_len   <= 3'd0;
            r_tx_idx   <= 3'd0;
            r_h2       <= 1'b0;
            r_data_in  <= 8'h00;
            r_ack      <= 1'b0;
            for (int k = 0; k < 6; k++) r_pkt[k] <= 8'h00;
            for (int k = 0; k < 5; k++) r_tx[k]  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_h2  <= 1'b0;
                    r_ack <= 1'b0;
                    if (r_start_sync) begin
                        r_byte_idx <= 3'd0;
                        r_state    <= ST_RX_WAIT_H1_HI;
                    end
                end
                ST_RX_WAIT_H1_HI: begin
                    if (!r_start_sync) begin
                        r_h2    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_h1_sync) begin
                        // Data has been stable since before h1 rose.
                        r_pkt[r_byte_idx] <= up_bus.uP_data_out;
                        r_h2              <= 1'b1;
                        r_state           <= ST_RX_WAIT_H1_LO;
                    end
                end
                ST_RX_WAIT_H1_LO: begin
                    if (!r_start_sync) begin
                        r_h2    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!r_h1_sync) begin
                        r_h2 <= 1'b0;
                        if (r_byte_idx == 3'd5) begin
                            r_state <= ST_EXECUTE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_state    <= ST_RX_WAIT_H1_HI;
                        end
                    end
                end
                ST_EXECUTE: begin
                    // Register writes happen this cycle via w_wr_en.
                    r_tx[0]   <= w_status;
                    r_tx[1]   <= w_rd_data[7:0];
                    r_tx[2]   <= w_rd_data[15:8];
                    r_tx[3]   <= w_rd_data[23:16];
                    r_tx[4]   <= w_rd_data[31:24];
                    r_tx_len  <= ((w_cmd == CMD_READ) && (w_status == STATUS_OK)) ? 3'd5 : 3'd1;
                    r_tx_idx  <= 3'd0;
                    r_data_in <= w_status;
                    r_state   <= ST_TX_WAIT_H1_HI;
                end
                ST_TX_WAIT_H1_HI: begin
                    // h2 rises one cycle after the byte is placed on the bus.
                    if (!r_start_sync) begin
                        r_h2    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_h2 && r_h1_sync) begin
                        r_h2    <= 1'b0;
                        r_state <= ST_TX_WAIT_H1_LO;
                    end else if (!r_h2 && !r_h1_sync) begin
                        r_h2 <= 1'b1;
                    end
                end
                ST_TX_WAIT_H1_LO: begin
                    if (!r_start_sync) begin
                        r_h2    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!r_h1_sync) begin
                        if (r_tx_idx == (r_tx_len - 3'd1)) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_tx_idx  <= r_tx_idx + 3'd1;
                            r_data_in <= r_tx[r_tx_idx + 3'd1];
                            r_state   <= ST_TX_WAIT_H1_HI;
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_start_sync) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_h2    <= 1'b0;
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_system_core.sv
// -----------------------------------------------------------------------------
// tb_motion_system_core
// Drives the uP side of the handshake bus and the encoder inputs; expected
// reply bytes are queued when a request is issued and compared as they arrive.
// -----------------------------------------------------------------------------
module tb_motion_system_core;
    import motion_system_core_pkg::*;

    localparam int NCH  = NOS_PWM_CHANNELS;
    localparam int NREG = 3 + 4 * NCH;

    logic           CLOCK_50 = 1'b0;
    logic           reset;
    logic [NCH-1:0] quadrature_A;
    logic [NCH-1:0] quadrature_B;
    logic [NCH-1:0] quadrature_I;
    logic [NCH-1:0] pwm_out;

    motion_system_core_if u_if ();

    motion_system_core dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .quadrature_A (quadrature_A),
        .quadrature_B (quadrature_B),
        .quadrature_I (quadrature_I),
        .up_bus       (u_if.slave),
        .pwm_out      (pwm_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    byte_t       q_exp [$];
    logic [31:0] m_regs [NREG];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = 32'd0;
        m_regs[0] = 32'h4D4F5431;
        m_regs[1] = 32'd1;   // busy bit is always set while a read executes
    endtask

    function automatic byte_t exp_status(input byte_t cmd, input byte_t regno);
        int r;
        r = int'(regno);
        if (cmd > 8'd1) return 8'h02;
        if (r >= NREG) return 8'h01;
        if (cmd == 8'd0 && (r == 0 || r == 1 || (r >= 3 && ((r - 3) % 4) == 3))) return 8'h01;
        return 8'h00;
    endfunction

    task automatic wait_h2(input logic lvl);
        int n;
        n = 0;
        while (u_if.uP_handshake_2 !== lvl && n < 64) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (u_if.uP_handshake_2 !== lvl)
            check_eq("h2_timeout", {31'd0, u_if.uP_handshake_2}, {31'd0, lvl});
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        while (u_if.uP_ack !== lvl && n < 64) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_eq(tag, {31'd0, u_if.uP_ack}, {31'd0, lvl});
    endtask

    task automatic send_byte(input byte_t b);
        @(negedge CLOCK_50);
        u_if.uP_data_out = b;
        @(negedge CLOCK_50);
        u_if.uP_handshake_1 = 1'b1;
        wait_h2(1'b1);
        u_if.uP_handshake_1 = 1'b0;
        wait_h2(1'b0);
    endtask

    task automatic recv_byte(output byte_t b);
        wait_h2(1'b1);
        b = u_if.uP_data_in;
        @(negedge CLOCK_50);
        u_if.uP_handshake_1 = 1'b1;
        wait_h2(1'b0);
        u_if.uP_handshake_1 = 1'b0;
    endtask

    // Full request/reply transaction with scoreboard bookkeeping.
    task automatic transact(input byte_t cmd, input byte_t regno, input logic [31:0] data);
        byte_t st;
        byte_t b;
        byte_t e;
        int    r;
        r  = int'(regno);
        st = exp_status(cmd, regno);
        q_exp.push_back(st);
        if (cmd == 8'd1 && st == 8'h00)
            for (int j = 0; j < 4; j++) q_exp.push_back(m_regs[r][8*j +: 8]);
        if (cmd == 8'd0 && st == 8'h00)
            m_regs[r] = (r >= 3 && ((r - 3) % 4) == 2) ? (data & 32'h3) : data;
        @(negedge CLOCK_50);
        u_if.uP_start = 1'b1;
        send_byte(cmd);
        send_byte(regno);
        for (int j = 0; j < 4; j++) send_byte(data[8*j +: 8]);
        while (q_exp.size() > 0) begin
            recv_byte(b);
            e = q_exp.pop_front();
            check_eq($sformatf("reply cmd%0d reg%0d", cmd, regno), {24'd0, b}, {24'd0, e});
        end
        wait_ack(1'b1, "ack_rise");
        @(negedge CLOCK_50);
        u_if.uP_start = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic quad_edge(input int ch, input logic a, input logic b, input int dir);
        quadrature_A[ch] = a;
        quadrature_B[ch] = b;
        m_regs[6 + 4*ch] = m_regs[6 + 4*ch] + 32'(dir);
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic pwm_measure(input string tag, input int exp_hi);
        int hi;
        int other;
        hi = 0;
        other = 0;
        repeat (6) @(negedge CLOCK_50);
        for (int k = 0; k < 100; k++) begin
            @(negedge CLOCK_50);
            if (pwm_out[1]) hi++;
            if ((pwm_out & 4'b1101) != 4'b0000) other++;
        end
        check_eq({tag, "_ch1_high"}, 32'(hi), 32'(exp_hi));
        check_eq({tag, "_others"}, 32'(other), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byte_t b;
        reset               = 1'b1;
        quadrature_A        = '0;
        quadrature_B        = '0;
        quadrature_I        = '0;
        u_if.uP_start       = 1'b0;
        u_if.uP_handshake_1 = 1'b0;
        u_if.uP_data_out    = 8'h00;
        model_reset();
        repeat (4) @(negedge CLOCK_50);
        check_eq("rst_h2",     {31'd0, u_if.uP_handshake_2}, 32'd0);
        check_eq("rst_ack",    {31'd0, u_if.uP_ack},         32'd0);
        check_eq("rst_data",   {24'd0, u_if.uP_data_in},     32'd0);
        check_eq("rst_pwm",    {28'd0, pwm_out},             32'd0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Basic write / read-back, ID and status registers
        transact(8'd0, 8'd3, 32'h0507002A);
        transact(8'd1, 8'd3, 32'h0);
        transact(8'd1, 8'd0, 32'hFFFFFFFF);
        transact(8'd1, 8'd1, 32'h0);
        transact(8'd0, 8'd2, 32'hDEADBEEF);
        transact(8'd1, 8'd2, 32'h0);

        // PWM on channel 1: 3/10, then on-time >= period, then disabled
        transact(8'd0, 8'd7, 32'd10);
        transact(8'd0, 8'd8, 32'd3);
        transact(8'd0, 8'd9, 32'd1);
        pwm_measure("pwm_3of10", 30);
        transact(8'd0, 8'd8, 32'd12);
        pwm_measure("pwm_full", 100);
        transact(8'd0, 8'd9, 32'd0);
        pwm_measure("pwm_off", 0);

        // Encoder on channel 0
        for (int s = 0; s < 5; s++) begin
            quad_edge(0, 1'b1, 1'b0, 1);
            quad_edge(0, 1'b1, 1'b1, 1);
            quad_edge(0, 1'b0, 1'b1, 1);
            quad_edge(0, 1'b0, 1'b0, 1);
        end
        transact(8'd1, 8'd6, 32'h0);
        for (int s = 0; s < 2; s++) begin
            quad_edge(0, 1'b0, 1'b1, -1);
            quad_edge(0, 1'b1, 1'b1, -1);
            quad_edge(0, 1'b1, 1'b0, -1);
            quad_edge(0, 1'b0, 1'b0, -1);
        end
        transact(8'd1, 8'd6, 32'h0);
        transact(8'd0, 8'd5, 32'd2);
        quadrature_I[0] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        quadrature_I[0] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        m_regs[6] = 32'd0;
        transact(8'd1, 8'd6, 32'h0);
        quad_edge(0, 1'b0, 1'b1, -1);
        transact(8'd1, 8'd6, 32'h0);
        quad_edge(0, 1'b0, 1'b0, 1);
        transact(8'd1, 8'd6, 32'h0);

        // Error cases leave the register file untouched
        transact(8'd0, 8'd200, 32'h12345678);
        transact(8'd7, 8'd3, 32'h12345678);
        transact(8'd0, 8'd0, 32'h12345678);
        transact(8'd0, 8'd6, 32'h12345678);
        transact(8'd1, 8'd19, 32'h0);
        transact(8'd1, 8'd3, 32'h0);
        transact(8'd1, 8'd6, 32'h0);

        // Abort by dropping uP_start after byte 3
        @(negedge CLOCK_50);
        u_if.uP_start = 1'b1;
        send_byte(8'd0);
        send_byte(8'd4);
        send_byte(8'h55);
        u_if.uP_start = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        check_eq("abort_h2",  {31'd0, u_if.uP_handshake_2}, 32'd0);
        check_eq("abort_ack", {31'd0, u_if.uP_ack},         32'd0);
        transact(8'd1, 8'd4, 32'h0);

        // Reset asserted while h2 is high mid-packet
        @(negedge CLOCK_50);
        u_if.uP_start = 1'b1;
        send_byte(8'd0);
        send_byte(8'd3);
        @(negedge CLOCK_50);
        u_if.uP_data_out = 8'h11;
        @(negedge CLOCK_50);
        u_if.uP_handshake_1 = 1'b1;
        wait_h2(1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_h2",   {31'd0, u_if.uP_handshake_2}, 32'd0);
        check_eq("mid_rst_data", {24'd0, u_if.uP_data_in},     32'd0);
        check_eq("mid_rst_ack",  {31'd0, u_if.uP_ack},         32'd0);
        repeat (3) @(negedge CLOCK_50);
        u_if.uP_handshake_1 = 1'b0;
        u_if.uP_start       = 1'b0;
        model_reset();
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        transact(8'd1, 8'd3, 32'h0);
        transact(8'd0, 8'd11, 32'hCAFE0001);
        transact(8'd1, 8'd11, 32'h0);

        b = 8'h00;
        if (q_exp.size() != 0) b = 8'h01;
        check_eq("scoreboard_empty", {24'd0, b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/motion_system_core.md
# motion_system_core

FPGA motion-control top level. It connects a host microprocessor (uP) to NOS_PWM_CHANNELS motor channels. A byte-wide, 4-phase handshaked packet bus carries commands that write and read a register file. Each channel holds a PWM generator and a quadrature-encoder position counter.

## Interface
- NOS_PWM_CHANNELS, 4 (from global constants): number of motor channels.
- CLOCK_50  in  1  system clock, 50 MHz; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- quadrature_A / quadrature_B / quadrature_I  in  NOS_PWM_CHANNELS each  encoder phase A, phase B and index per channel; asynchronous to the clock.
- uP_start  in  1  uP holds this high for the duration of a transaction.
- uP_handshake_1  in  1  uP strobe.
- uP_data_out  in  8 (byte_t)  byte from uP to FPGA.
- uP_handshake_2  out  1  FPGA strobe.
- uP_data_in  out  8 (byte_t)  byte from FPGA to uP.
- uP_ack  out  1  transaction complete.
- pwm_out  out  NOS_PWM_CHANNELS  PWM output per channel.

## Operation
- **Reset values:** every register, counter and output is 0, including uP_handshake_2, uP_ack, uP_data_in and pwm_out.
- **Request packet:** 6 bytes in order:
  - command: 0 = write, 1 = read;
  - register number;
  - data bytes 0..3, LSB first. Bytes 42,0,7,5 give 0x0507002A.
  - On a read the data bytes are sent but ignored.
- **Receive byte (4-phase):**
  - uP drives uP_data_out, then raises h1.
  - FPGA latches the byte and raises h2.
  - uP drops h1; FPGA drops h2.
- **Send byte (4-phase):**
  - FPGA drives uP_data_in, then raises h2.
  - uP samples the byte, then raises h1.
  - FPGA drops h2; uP drops h1.
  - uP_data_in stays stable from h2 rise until h1 rise.
- **Reply packet:**
  - Status byte: 0x00 OK, 0x01 bad register, 0x02 bad command.
  - A read with OK status is followed by 4 data bytes, LSB first.
  - A write, or any error, gets the status byte only.
- **Register map** (32-bit):
  - 0: ID, read-only, 0x4D4F5431.
  - 1: global status, read-only: bit0 = transaction busy.
  - 2: global config, R/W, spare.
  - Channel n base = 3+4n:
    - +0 PWM period;
    - +1 PWM on-time;
    - +2 config (bit0 PWM enable, bit1 index-clear enable);
    - +3 encoder count, read-only, two's complement.
  - Register number ≥ 3+4·NOS_PWM_CHANNELS → bad register.
  - A write to a read-only register → bad register, with no effect.
- **Error handling:** on bad register or bad command no register changes, and the packet still completes normally.
- **PWM:**
  - When enabled and period ≠ 0, a 32-bit counter runs 0..period−1 and wraps.
  - pwm_out = (counter < on_time).
  - on_time ≥ period gives constant 1. Period 0 or disabled gives output 0 and counter held at 0.
  - A period write while running takes effect at the next wrap.
- **Encoder:**
  - A, B and I are each synchronised through 2 flops.
  - x4 decode: A leading B increments, B leading A decrements.
  - An invalid transition (both phases changing) is ignored.
  - Count wraps modulo 2^32.
  - A rising edge of I with index-clear enabled sets the count to 0; this wins over a simultaneous count step.
- **FSM:**
  - States: IDLE, RX_WAIT_H1_HI, RX_WAIT_H1_LO, EXECUTE, TX_WAIT_H1_HI, TX_WAIT_H1_LO, DONE.
  - IDLE goes to RX when synchronised uP_start = 1.
  - After 6 bytes, EXECUTE takes 1 cycle, then TX.
  - After the last reply byte, DONE asserts uP_ack and holds it until uP_start = 0, then goes to IDLE.
  - uP_start falling in any RX/TX state aborts to IDLE: h2 = 0, no write.

## Timing
- uP_start and uP_handshake_1 are 2-flop synchronised.
- h2 changes ≤4 cycles after the synchronised h1 edge.
- A register write takes effect in the EXECUTE cycle.
- The first reply byte's h2 rises ≤3 cycles after EXECUTE.
- Reset asserted mid-transaction forces IDLE immediately and asynchronously, with all outputs 0.

## Structure
- **Shared package `types`:** byte_t, command codes, status codes, register offsets, ID constant. NOS_PWM_CHANNELS stays in global_constants.
- **Sub-module `motion_channel`:** one per channel, generated. It holds the period, on-time and config registers, the PWM counter, and the quadrature decoder/counter.
- **Top level:** the FSM and register decode.

## Test plan
- Write cmd 0, reg 3, data 42,0,7,5 → one reply byte 0x00; channel 0 period = 0x0507002A; uP_ack rises; drops after uP_start = 0.
- Write period 10, on-time 3, config 1 to channel 1 → pwm_out[1] high 3 of every 10 cycles; other channels stay 0.
- Read reg 0 → reply 0x00, 0x31, 0x54, 0x4F, 0x4D.
- Drive 5 forward quadrature steps (20 edges) on channel 0, then read reg 6 → count 20. Reverse 8 edges → 12. Index pulse with config bit1 set → 0.
- Write reg 200 → status 0x01. Command 7 → status 0x02. No register changes in either case.
- Drop uP_start after byte 3, or assert reset mid-packet → h2 = 0, FSM in IDLE, no write; the next full transaction succeeds.
